// File: rtl/cplx_addsub_pipe_pkg.sv
// Shared packed-complex format: {Re, Im}, each a signed two's-complement component.
// Holds the component/word widths, field helpers and the add/sub mode encoding.
package cplx_addsub_pipe_pkg;

  localparam int CPLX_W      = 8;
  localparam int CPLX_WORD_W = 2 * CPLX_W;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic logic signed [CPLX_W-1:0] cplx_re(input logic [CPLX_WORD_W-1:0] w);
    return $signed(w[CPLX_WORD_W-1:CPLX_W]);
  endfunction

  function automatic logic signed [CPLX_W-1:0] cplx_im(input logic [CPLX_WORD_W-1:0] w);
    return $signed(w[CPLX_W-1:0]);
  endfunction

  function automatic logic [CPLX_WORD_W-1:0] cplx_pack(input logic signed [CPLX_W-1:0] re,
                                                       input logic signed [CPLX_W-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/cplx_comp_addsub.sv
// Single signed component add/subtract with overflow detect.
// Define CPLX_ADDSUB_SAT_EN to saturate overflowing results instead of wrapping.
module cplx_comp_addsub
  import cplx_addsub_pipe_pkg::*;
#(
  parameter int W = CPLX_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W-1:0] res,
  output logic         ovf
);

  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] sum;
  logic       is_sub;

  // Work at W+1 bits so that a - (-2^(W-1)) is representable before the range check.
  always_comb begin
    is_sub = (mode == MODE_SUB);
    a_ext  = {a[W-1], a};
    b_ext  = is_sub ? ~{b[W-1], b} : {b[W-1], b};
    sum    = a_ext + b_ext + {{W{1'b0}}, is_sub};
    ovf    = sum[W] ^ sum[W-1];
`ifdef CPLX_ADDSUB_SAT_EN
    if (ovf)
      res = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      res = sum[W-1:0];
`else
    res = sum[W-1:0];
`endif
  end

endmodule

// File: rtl/cplx_addsub_pipe.sv
// Two-stage valid/ready complex add/subtract pipeline (S1 operands, S2 result).
// Build with CPLX_ADDSUB_SAT_EN defined for saturating components; default wraps.
module cplx_addsub_pipe
  import cplx_addsub_pipe_pkg::*;
#(
  parameter int W     = CPLX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_a,
  input  logic [2*W-1:0]   in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_res,
  output logic [1:0]       out_ovf,
  output logic [CNT_W-1:0] op_count
);

  logic [2*W-1:0] s1_a;
  logic [2*W-1:0] s1_b;
  logic           s1_mode;
  logic           s1_valid;

  logic           s2_free;
  logic           s1_adv;
  logic           in_xfer;
  logic           out_xfer;

  logic [W-1:0]   res_re;
  logic [W-1:0]   res_im;
  logic           ovf_re;
  logic           ovf_im;

  // in_ready depends only on stage state and out_ready, never on in_valid.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  end

  cplx_comp_addsub #(.W(W)) u_re (
    .a    (s1_a[2*W-1:W]),
    .b    (s1_b[2*W-1:W]),
    .mode (s1_mode),
    .res  (res_re),
    .ovf  (ovf_re)
  );

  cplx_comp_addsub #(.W(W)) u_im (
    .a    (s1_a[W-1:0]),
    .b    (s1_b[W-1:0]),
    .mode (s1_mode),
    .res  (res_im),
    .ovf  (ovf_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= MODE_ADD;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_mode  <= in_mode;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_ovf   <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_res   <= {res_re, res_im};
      out_ovf   <= {ovf_re, ovf_im};
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (out_xfer)
      op_count <= op_count + 1'b1;
  end

endmodule
